// File: rtl/timing_decode_unit.sv
// Sequence counter, run flag and instruction register of the accumulator CPU.
// Produces the T/D/B/J timing and decode signals consumed by the control logic.
module timing_decode_unit #(
  parameter int MEM_END = 5,
  parameter int REG_END = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic        mem_rd,
  output logic [7:0]  T,
  output logic [7:0]  D,
  output logic [3:0]  B,
  output logic        J,
  output logic [15:0] ir,
  output logic        running
);

  localparam logic [2:0] MEM_SC = 3'(MEM_END);
  localparam logic [2:0] REG_SC = 3'(REG_END);

  logic [2:0]  sc_q, sc_d;
  logic        s_q, s_d;
  logic [15:0] ir_q, ir_d;
  logic        d7;
  logic        j_bit;
  logic        rd_req;

  assign d7    = (ir_q[14:12] == 3'd7);
  assign j_bit = ir_q[15];

  // Memory handshake: a request (mem_rd) stays up and SC holds until a cycle
  // in which mem_valid is also high; that cycle completes the transfer.
  // mem_valid seen without an outstanding request has no effect.
  always_comb begin
    rd_req = 1'b0;
    if (s_q) begin
      rd_req = (sc_q == 3'd1) ||
               ((sc_q == 3'd3) && !d7 && j_bit) ||
               ((sc_q == 3'd4) && !d7);
    end
  end

  always_comb begin
    sc_d = sc_q;
    s_d  = s_q;
    ir_d = ir_q;
    if (!s_q) begin
      if (start) begin
        s_d  = 1'b1;
        sc_d = 3'd0;
      end
    end else if (rd_req && !mem_valid) begin
      sc_d = sc_q;
    end else if (sc_q == 3'd1) begin
      ir_d = mem_data;
      sc_d = 3'd2;
    end else if (d7 && (sc_q == REG_SC)) begin
      // Register reference or unimplemented I/O: instruction ends here.
      sc_d = 3'd0;
      if (!j_bit && ir_q[0]) begin
        s_d = 1'b0;
      end
    end else if (!d7 && (sc_q == MEM_SC)) begin
      sc_d = 3'd0;
    end else begin
      sc_d = sc_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= 3'd0;
      s_q  <= 1'b0;
      ir_q <= 16'h0000;
    end else begin
      sc_q <= sc_d;
      s_q  <= s_d;
      ir_q <= ir_d;
    end
  end

  assign T       = s_q ? (8'h01 << sc_q) : 8'h00;
  assign D       = 8'h01 << ir_q[14:12];
  assign B       = ir_q[3:0];
  assign J       = ir_q[15];
  assign ir      = ir_q;
  assign running = s_q;
  assign mem_rd  = rd_req;

endmodule
